// File: rtl/counter_mod_param.sv
// Parametrised modulo-MODULUS up-counter with enable, synchronous clear, terminal-count flag
// and sticky done; one-shot or free-running. Optional load path under COUNTER_MOD_LOAD_EN.
module counter_mod_param #(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned MODULUS  = 5,
  parameter bit          ONE_SHOT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclr,
  input  logic             en,
`ifdef COUNTER_MOD_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`endif
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             done
);

  localparam longint unsigned SPAN = 64'd1 << WIDTH;
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  // Reject parameter sets that cannot hold the full count sequence.
  if (WIDTH < 1 || MODULUS < 2 || 64'(MODULUS) > SPAN) begin : g_param_err
    $error("counter_mod_param: illegal WIDTH/MODULUS combination");
  end

  logic [WIDTH-1:0] out_nxt;
  logic             done_nxt;
  logic             done_halt;
  logic             at_last;

  assign done_halt = ONE_SHOT && done;
  assign at_last   = (out == LAST);
  assign tc        = en && at_last && !done_halt;

  // Next-state: sclr > load > en > hold.
  always_comb begin
    out_nxt  = out;
    done_nxt = done;
    if (sclr) begin
      out_nxt  = '0;
      done_nxt = 1'b0;
    end
`ifdef COUNTER_MOD_LOAD_EN
    else if (load) begin
      out_nxt  = (load_val > LAST) ? LAST : load_val;
      done_nxt = 1'b0;
    end
`endif
    else if (en && !done_halt) begin
      if (at_last) begin
        out_nxt  = '0;
        done_nxt = 1'b1;
      end else begin
        out_nxt  = out + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out  <= '0;
      done <= 1'b0;
    end else begin
      out  <= out_nxt;
      done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_counter_mod_param.sv
// Directed self-checking bench for counter_mod_param: one-shot, free-running and
// full-range instances share stimulus; each task checks the instance it targets.
module tb_counter_mod_param;

  logic clk = 1'b0;
  logic rst, sclr, en;
  logic [2:0] out_a, out_b;
  logic [3:0] out_c;
  logic tc_a, tc_b, tc_c, done_a, done_b, done_c;
  int checks = 0;
  int errors = 0;
`ifdef COUNTER_MOD_LOAD_EN
  logic       load;
  logic [2:0] load_val;
  logic [3:0] load_val_c;
`endif

  always #5 clk = ~clk;

  counter_mod_param #(.WIDTH(3), .MODULUS(5), .ONE_SHOT(1'b1)) u_a (
    .clk(clk), .rst(rst), .sclr(sclr), .en(en),
`ifdef COUNTER_MOD_LOAD_EN
    .load(load), .load_val(load_val),
`endif
    .out(out_a), .tc(tc_a), .done(done_a));

  counter_mod_param #(.WIDTH(3), .MODULUS(5), .ONE_SHOT(1'b0)) u_b (
    .clk(clk), .rst(rst), .sclr(sclr), .en(en),
`ifdef COUNTER_MOD_LOAD_EN
    .load(load), .load_val(load_val),
`endif
    .out(out_b), .tc(tc_b), .done(done_b));

  counter_mod_param #(.WIDTH(4), .MODULUS(16), .ONE_SHOT(1'b0)) u_c (
    .clk(clk), .rst(rst), .sclr(sclr), .en(en),
`ifdef COUNTER_MOD_LOAD_EN
    .load(load), .load_val(load_val_c),
`endif
    .out(out_c), .tc(tc_c), .done(done_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; sclr = 1'b0; en = 1'b0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_a !== 3'd0 || done_a !== 1'b0 || tc_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_state out=%0d done=%b tc=%b expected 0 0 0", out_a, done_a, tc_a);
    end
    en = 1'b1;
    repeat (3) tick();
    checks++;
    if (out_a !== 3'd3) begin
      errors++;
      $display("FAIL reset_precount out=%0d expected 3", out_a);
    end
    // Assert rst well away from any edge; clear must be visible before the next edge.
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_a !== 3'd0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_async out=%0d done=%b expected 0 0", out_a, done_a);
    end
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    tick();
    checks++;
    if (out_a !== 3'd0) begin
      errors++;
      $display("FAIL reset_release_hold out=%0d expected 0", out_a);
    end
  endtask

  task automatic test_one_shot();
    do_reset();
    en = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_a !== 3'(i) || tc_a !== (i == 4) || done_a !== 1'b0) begin
        errors++;
        $display("FAIL one_shot_count[%0d] out=%0d tc=%b done=%b expected %0d %b 0",
                 i, out_a, tc_a, done_a, i, (i == 4));
      end
      tick();
    end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (out_a !== 3'd0 || tc_a !== 1'b0 || done_a !== 1'b1) begin
        errors++;
        $display("FAIL one_shot_halt[%0d] out=%0d tc=%b done=%b expected 0 0 1",
                 i, out_a, tc_a, done_a);
      end
      tick();
    end
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
    #1;
    checks++;
    if (out_a !== 3'd0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL one_shot_sclr out=%0d done=%b expected 0 0", out_a, done_a);
    end
    tick();
    checks++;
    if (out_a !== 3'd1) begin
      errors++;
      $display("FAIL one_shot_resume out=%0d expected 1", out_a);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    en = 1'b1;
    #1;
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (out_b !== 3'(c % 5) || tc_b !== ((c % 5) == 4) || done_b !== (c >= 5)) begin
        errors++;
        $display("FAIL wrap_cycle[%0d] out=%0d tc=%b done=%b expected %0d %b %b",
                 c, out_b, tc_b, done_b, c % 5, ((c % 5) == 4), (c >= 5));
      end
      tick();
    end
  endtask

  task automatic test_enable_toggle();
    logic [2:0] exp_out [4] = '{3'd3, 3'd3, 3'd4, 3'd4};
    logic       pat     [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    en = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < 4; i++) begin
      en = pat[i];
      tick();
      checks++;
      if (out_a !== exp_out[i]) begin
        errors++;
        $display("FAIL en_toggle[%0d] out=%0d expected %0d", i, out_a, exp_out[i]);
      end
    end
    en = 1'b1; sclr = 1'b1;
    #1;
    checks++;
    if (tc_a !== 1'b1) begin
      errors++;
      $display("FAIL sclr_tc_same_cycle tc=%b expected 1", tc_a);
    end
    tick();
    sclr = 1'b0; en = 1'b0;
    checks++;
    if (out_a !== 3'd0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL sclr_beats_en out=%0d done=%b expected 0 0", out_a, done_a);
    end
  endtask

  task automatic test_mod16();
    do_reset();
    en = 1'b1;
    #1;
    for (int c = 0; c < 18; c++) begin
      checks++;
      if (out_c !== 4'(c % 16) || tc_c !== (c == 15) || done_c !== (c >= 16)) begin
        errors++;
        $display("FAIL mod16_cycle[%0d] out=%0h tc=%b done=%b expected %0d %b %b",
                 c, out_c, tc_c, done_c, c % 16, (c == 15), (c >= 16));
      end
      tick();
    end
    en = 1'b0;
  endtask

`ifdef COUNTER_MOD_LOAD_EN
  task automatic test_load();
    do_reset();
    load = 1'b1; load_val = 3'd3;
    tick();
    checks++;
    if (out_a !== 3'd3 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL load_3 out=%0d done=%b expected 3 0", out_a, done_a);
    end
    load_val = 3'd7;
    tick();
    checks++;
    if (out_a !== 3'd4) begin
      errors++;
      $display("FAIL load_clamp out=%0d expected 4", out_a);
    end
    load = 1'b0; en = 1'b1;
    repeat (2) tick();
    checks++;
    if (out_a !== 3'd0 || done_a !== 1'b1) begin
      errors++;
      $display("FAIL load_pre_halt out=%0d done=%b expected 0 1", out_a, done_a);
    end
    load = 1'b1; load_val = 3'd2;
    tick();
    load = 1'b0;
    checks++;
    if (out_a !== 3'd2 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL load_unhalt out=%0d done=%b expected 2 0", out_a, done_a);
    end
    tick();
    checks++;
    if (out_a !== 3'd3) begin
      errors++;
      $display("FAIL load_resume out=%0d expected 3", out_a);
    end
    sclr = 1'b1; load = 1'b1; load_val = 3'd1;
    tick();
    sclr = 1'b0; load = 1'b0; en = 1'b0;
    checks++;
    if (out_a !== 3'd0) begin
      errors++;
      $display("FAIL sclr_beats_load out=%0d expected 0", out_a);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; sclr = 1'b0; en = 1'b0;
`ifdef COUNTER_MOD_LOAD_EN
    load = 1'b0; load_val = 3'd0; load_val_c = 4'd0;
`endif
    test_reset();
    test_one_shot();
    test_wrap();
    test_enable_toggle();
    test_mod16();
`ifdef COUNTER_MOD_LOAD_EN
    test_load();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
